// File: rtl/fechadura_pkg.sv
// Shared types and default timing for the digital lock datapath.
package fechadura_pkg;

  typedef enum logic [1:0] {
    TRAVADO,
    DESTRAVADO,
    BLOQUEADO,
    SETUP
  } estado_acesso_t;

  // Defaults assume a 50 MHz clock: 1 s release, 3 s lockout, 30 s setup idle.
  localparam int          MAX_FALHAS_DEF = 3;
  localparam int unsigned T_DESTRAVA_DEF = 32'd50_000_000;
  localparam int unsigned T_BLOQUEIO_DEF = 32'd150_000_000;
  localparam int unsigned T_SETUP_DEF    = 32'd1_500_000_000;
  localparam int          TW_DEF         = 32;

endpackage

// File: rtl/temporizador_ciclos.sv
// Down-counter shared by all timed states; loads on request, holds at zero.
module temporizador_ciclos #(
  parameter int TW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          expired
);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)             cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/controle_acesso.sv
// Access control FSM: turns verifier verdicts into lock release, lockout and
// setup-mode grants, with a consecutive-failure counter.
module controle_acesso
  import fechadura_pkg::*;
#(
  parameter int          MAX_FALHAS = MAX_FALHAS_DEF,
  parameter int unsigned T_DESTRAVA = T_DESTRAVA_DEF,
  parameter int unsigned T_BLOQUEIO = T_BLOQUEIO_DEF,
  parameter int unsigned T_SETUP    = T_SETUP_DEF,
  parameter int          TW         = TW_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       senha_fail,
  input  logic       senha_padrao,
  input  logic       senha_master,
  input  logic       botao_interno,
  input  logic       sensor_porta,
  input  logic       setup_done,
  output logic       tranca,
  output logic       bloqueado,
  output logic       setup_mode,
  output logic       pin_enable,
  output logic       bip,
  output logic [3:0] cont_falhas
);

  localparam logic [TW-1:0] LD_DESTRAVA = TW'(T_DESTRAVA - 1);
  localparam logic [TW-1:0] LD_BLOQUEIO = TW'(T_BLOQUEIO - 1);
  localparam logic [TW-1:0] LD_SETUP    = TW'(T_SETUP - 1);
  localparam logic [4:0]    MAX_F       = 5'(MAX_FALHAS);

  estado_acesso_t estado, proximo;
  logic           fail_q, padrao_q, master_q, botao_q;
  logic           ev_fail, ev_padrao, ev_master, ev_botao;
  logic           carrega, expirou, conta_falha;
  logic [TW-1:0]  valor;
  logic [4:0]     falhas_mais1;

  assign ev_fail      = senha_fail    & ~fail_q;
  assign ev_padrao    = senha_padrao  & ~padrao_q;
  assign ev_master    = senha_master  & ~master_q;
  assign ev_botao     = botao_interno & ~botao_q;
  assign falhas_mais1 = {1'b0, cont_falhas} + 5'd1;

  temporizador_ciclos #(.TW(TW)) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (carrega),
    .load_val (valor),
    .expired  (expirou)
  );

  // Only the highest-priority event acts; lower edges in the same cycle are dropped.
  always_comb begin
    proximo     = estado;
    carrega     = 1'b0;
    valor       = '0;
    conta_falha = 1'b0;
    case (estado)
      TRAVADO: begin
        if (ev_master) begin
          proximo = SETUP;      carrega = 1'b1; valor = LD_SETUP;
        end else if (ev_padrao || ev_botao) begin
          proximo = DESTRAVADO; carrega = 1'b1; valor = LD_DESTRAVA;
        end else if (ev_fail) begin
          conta_falha = 1'b1;
          if (falhas_mais1 == MAX_F) begin
            proximo = BLOQUEADO; carrega = 1'b1; valor = LD_BLOQUEIO;
          end
        end
      end
      DESTRAVADO: begin
        // Open door keeps the lock released with the timer parked at zero.
        if (ev_botao) begin
          carrega = 1'b1; valor = LD_DESTRAVA;
        end else if (expirou && !sensor_porta) begin
          proximo = TRAVADO;
        end
      end
      BLOQUEADO: begin
        if (ev_botao) begin
          proximo = DESTRAVADO; carrega = 1'b1; valor = LD_DESTRAVA;
        end else if (expirou) begin
          proximo = TRAVADO;
        end
      end
      SETUP: begin
        if (ev_botao) begin
          proximo = DESTRAVADO; carrega = 1'b1; valor = LD_DESTRAVA;
        end else if (setup_done || expirou) begin
          proximo = TRAVADO;
        end
      end
      default: proximo = TRAVADO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado      <= TRAVADO;
      fail_q      <= 1'b0;
      padrao_q    <= 1'b0;
      master_q    <= 1'b0;
      botao_q     <= 1'b0;
      cont_falhas <= 4'd0;
      tranca      <= 1'b0;
      bloqueado   <= 1'b0;
      setup_mode  <= 1'b0;
      pin_enable  <= 1'b1;
      bip         <= 1'b0;
    end else begin
      fail_q      <= senha_fail;
      padrao_q    <= senha_padrao;
      master_q    <= senha_master;
      botao_q     <= botao_interno;
      estado      <= proximo;
      bip         <= conta_falha;
      if (proximo != TRAVADO) cont_falhas <= 4'd0;
      else if (conta_falha)   cont_falhas <= cont_falhas + 4'd1;
      tranca      <= (proximo == DESTRAVADO);
      bloqueado   <= (proximo == BLOQUEADO);
      setup_mode  <= (proximo == SETUP);
      pin_enable  <= (proximo == TRAVADO) || (proximo == SETUP);
    end
  end

endmodule

// File: tb/tb_controle_acesso.sv
// Directed checks of controle_acesso with short timers.
module tb_controle_acesso;

  logic       clk = 1'b0;
  logic       rst, senha_fail, senha_padrao, senha_master;
  logic       botao_interno, sensor_porta, setup_done;
  logic       tranca, bloqueado, setup_mode, pin_enable, bip;
  logic [3:0] cont_falhas;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  controle_acesso #(
    .MAX_FALHAS (3),
    .T_DESTRAVA (8),
    .T_BLOQUEIO (16),
    .T_SETUP    (32),
    .TW         (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .senha_fail    (senha_fail),
    .senha_padrao  (senha_padrao),
    .senha_master  (senha_master),
    .botao_interno (botao_interno),
    .sensor_porta  (sensor_porta),
    .setup_done    (setup_done),
    .tranca        (tranca),
    .bloqueado     (bloqueado),
    .setup_mode    (setup_mode),
    .pin_enable    (pin_enable),
    .bip           (bip),
    .cont_falhas   (cont_falhas)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance n clocks; outputs are sampled 1 time unit after the edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle fail pulse; returns after the following idle cycle.
  task automatic pulso_fail(input string tag, input logic [3:0] cnt_exp,
                            input logic bip_exp, input logic blq_exp);
    senha_fail = 1'b1;
    step(1);
    chk({tag, ".cont"}, cont_falhas, cnt_exp);
    chk({tag, ".bip"},  bip,         bip_exp);
    chk({tag, ".blq"},  bloqueado,   blq_exp);
    senha_fail = 1'b0;
    step(1);
    chk({tag, ".bip_off"}, bip, 1'b0);
  endtask

  initial begin
    rst = 1'b1; senha_fail = 1'b0; senha_padrao = 1'b0; senha_master = 1'b0;
    botao_interno = 1'b0; sensor_porta = 1'b0; setup_done = 1'b0;
    #1;
    step(2);
    rst = 1'b0;
    chk("rst.tranca", tranca,      1'b0);
    chk("rst.pin_en", pin_enable,  1'b1);
    chk("rst.cont",   cont_falhas, 4'd0);
    chk("rst.blq",    bloqueado,   1'b0);
    chk("rst.setup",  setup_mode,  1'b0);
    chk("rst.bip",    bip,         1'b0);
    step(1);
    chk("idle.tranca", tranca, 1'b0);

    // Held padrao level -> a single 8-cycle unlock
    senha_padrao = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      chk("unlk.tranca", tranca, 1'b1);
      chk("unlk.pin_en", pin_enable, 1'b0);
      if (i == 5) senha_padrao = 1'b0;
    end
    step(1);
    chk("unlk.relock", tranca, 1'b0);
    step(4);
    chk("unlk.once", tranca, 1'b0);

    // Lockout after three failures
    pulso_fail("f1", 4'd1, 1'b1, 1'b0);
    pulso_fail("f2", 4'd2, 1'b1, 1'b0);
    pulso_fail("f3", 4'd0, 1'b1, 1'b1);       // samples 1-2 of lockout
    chk("blq.pin_en", pin_enable, 1'b0);
    pulso_fail("f4", 4'd0, 1'b0, 1'b1);       // samples 3-4, ignored
    senha_padrao = 1'b1;
    step(1);
    chk("blq.padrao", tranca, 1'b0);           // sample 5
    senha_padrao = 1'b0;
    step(11);
    chk("blq.end16", bloqueado, 1'b1);         // sample 16
    step(1);
    chk("blq.exit", bloqueado, 1'b0);          // sample 17
    chk("blq.exit_pin", pin_enable, 1'b1);

    // Door held open past expiry
    sensor_porta = 1'b1;
    senha_padrao = 1'b1;
    step(1);
    senha_padrao = 1'b0;
    chk("door.s1", tranca, 1'b1);
    step(10);
    chk("door.s11", tranca, 1'b1);
    step(1);
    chk("door.s12", tranca, 1'b1);
    sensor_porta = 1'b0;
    step(1);
    chk("door.close", tranca, 1'b0);

    // Success clears the failure count
    pulso_fail("g1", 4'd1, 1'b1, 1'b0);
    pulso_fail("g2", 4'd2, 1'b1, 1'b0);
    senha_padrao = 1'b1;
    step(1);
    senha_padrao = 1'b0;
    chk("clr.cont", cont_falhas, 4'd0);
    chk("clr.tranca", tranca, 1'b1);
    step(8);
    chk("clr.relock", tranca, 1'b0);
    pulso_fail("g3", 4'd1, 1'b1, 1'b0);

    // master wins over padrao in the same cycle; setup_done exit
    senha_master = 1'b1; senha_padrao = 1'b1;
    step(1);
    senha_master = 1'b0; senha_padrao = 1'b0;
    chk("set.mode",   setup_mode,  1'b1);
    chk("set.tranca", tranca,      1'b0);
    chk("set.cont",   cont_falhas, 4'd0);
    chk("set.pin_en", pin_enable,  1'b1);
    step(9);
    chk("set.s10", setup_mode, 1'b1);
    setup_done = 1'b1;
    step(1);
    setup_done = 1'b0;
    chk("set.done", setup_mode, 1'b0);

    // Setup inactivity timeout
    senha_master = 1'b1;
    step(1);
    senha_master = 1'b0;
    chk("to.s1", setup_mode, 1'b1);
    step(31);
    chk("to.s32", setup_mode, 1'b1);
    step(1);
    chk("to.exit", setup_mode, 1'b0);

    // Egress button during lockout
    pulso_fail("h1", 4'd1, 1'b1, 1'b0);
    pulso_fail("h2", 4'd2, 1'b1, 1'b0);
    pulso_fail("h3", 4'd0, 1'b1, 1'b1);
    botao_interno = 1'b1;
    step(1);
    botao_interno = 1'b0;
    chk("egr.tranca", tranca,    1'b1);
    chk("egr.blq",    bloqueado, 1'b0);
    step(7);
    chk("egr.s8", tranca, 1'b1);
    step(1);
    chk("egr.relock", tranca, 1'b0);

    // Reset mid-unlock
    pulso_fail("r1", 4'd1, 1'b1, 1'b0);
    botao_interno = 1'b1;
    step(1);
    botao_interno = 1'b0;
    chk("abort.pre", tranca, 1'b1);
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("abort.tranca", tranca,      1'b0);
    chk("abort.pin_en", pin_enable,  1'b1);
    chk("abort.cont",   cont_falhas, 4'd0);
    step(3);
    chk("abort.stay", tranca, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
